// File: rtl/video_timing_pkg.sv
// Shared timing types and helpers for the raster timing generator.
// One timing_t describes a complete frame geometry plus sync polarities.
package video_timing_pkg;

    localparam int TCW = 12;

    typedef struct packed {
        logic [TCW-1:0] h_active;
        logic [TCW-1:0] h_fp;
        logic [TCW-1:0] h_sync;
        logic [TCW-1:0] h_bp;
        logic [TCW-1:0] v_active;
        logic [TCW-1:0] v_fp;
        logic [TCW-1:0] v_sync;
        logic [TCW-1:0] v_bp;
        logic           hs_pol;
        logic           vs_pol;
    } timing_t;

    localparam timing_t TIMING_640x480_60 = '{
        h_active: TCW'(640),
        h_fp:     TCW'(16),
        h_sync:   TCW'(96),
        h_bp:     TCW'(48),
        v_active: TCW'(480),
        v_fp:     TCW'(10),
        v_sync:   TCW'(2),
        v_bp:     TCW'(33),
        hs_pol:   1'b0,
        vs_pol:   1'b0
    };

    // Totals are summed two bits wider so an overflowing config is visible.
    function automatic logic timing_valid(timing_t t);
        logic [TCW+1:0] ht;
        logic [TCW+1:0] vt;
        logic [TCW+1:0] lim;
        ht  = (TCW+2)'(t.h_active) + (TCW+2)'(t.h_fp)
            + (TCW+2)'(t.h_sync) + (TCW+2)'(t.h_bp);
        vt  = (TCW+2)'(t.v_active) + (TCW+2)'(t.v_fp)
            + (TCW+2)'(t.v_sync) + (TCW+2)'(t.v_bp);
        lim = {2'b00, {TCW{1'b1}}};
        return (t.h_active != '0) && (t.h_sync != '0)
            && (t.v_active != '0) && (t.v_sync != '0)
            && (ht <= lim) && (vt <= lim);
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, registered sync/de decode and a
// shadow config register that is applied only at the frame wrap.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic          pxl_clk,
    input  logic          rst,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_hs_pol,
    input  logic          cfg_vs_pol,
    input  logic          cfg_load,
    output logic          cfg_pending,
    output logic          cfg_err,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam timing_t DEF = '{
        h_active: TCW'(H_ACTIVE),
        h_fp:     TCW'(H_FP),
        h_sync:   TCW'(H_SYNC),
        h_bp:     TCW'(H_BP),
        v_active: TCW'(V_ACTIVE),
        v_fp:     TCW'(V_FP),
        v_sync:   TCW'(V_SYNC),
        v_bp:     TCW'(V_BP),
        hs_pol:   1'(HS_POL),
        vs_pol:   1'(VS_POL)
    };
    localparam logic [CW-1:0] ONE = CW'(1);

    timing_t       act_q, act_d, shd_q, shd_d, new_cfg;
    logic          pend_q, pend_d, err_q, err_d;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic          ls_q, ls_d, fs_q, fs_d;

    logic [CW-1:0] ht, vt, hs_start, hs_end, vs_start, vs_end;
    logic          h_last, v_last, wrap, load_ok;
    logic          in_hs, vs_on, vs_off, in_vs;

    always_comb begin
        new_cfg = '{
            h_active: cfg_h_active, h_fp: cfg_h_fp,
            h_sync:   cfg_h_sync,   h_bp: cfg_h_bp,
            v_active: cfg_v_active, v_fp: cfg_v_fp,
            v_sync:   cfg_v_sync,   v_bp: cfg_v_bp,
            hs_pol:   cfg_hs_pol,   vs_pol: cfg_vs_pol
        };
        load_ok = cfg_load && timing_valid(new_cfg);
        err_d   = cfg_load && !timing_valid(new_cfg);

        ht     = act_q.h_active + act_q.h_fp + act_q.h_sync + act_q.h_bp;
        vt     = act_q.v_active + act_q.v_fp + act_q.v_sync + act_q.v_bp;
        h_last = (h_q == ht - ONE);
        v_last = (v_q == vt - ONE);
        wrap   = h_last && v_last;

        h_d = h_last ? '0 : h_q + ONE;
        v_d = v_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + ONE;
        end

        // The held shadow is consumed first; a same-cycle load re-arms it.
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        if (wrap && pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
        if (load_ok) begin
            shd_d  = new_cfg;
            pend_d = 1'b1;
        end

        hs_start = act_q.h_active + act_q.h_fp;
        hs_end   = hs_start + act_q.h_sync;
        vs_start = act_q.v_active + act_q.v_fp;
        vs_end   = vs_start + act_q.v_sync;

        in_hs  = (h_q >= hs_start) && (h_q < hs_end);
        // Both vsync edges line up with the hsync leading edge.
        vs_on  = (v_q > vs_start) || ((v_q == vs_start) && (h_q >= hs_start));
        vs_off = (v_q > vs_end) || ((v_q == vs_end) && (h_q >= hs_start));
        in_vs  = vs_on && !vs_off;

        de_d = (h_q < act_q.h_active) && (v_q < act_q.v_active);
        hs_d = in_hs ? act_q.hs_pol : ~act_q.hs_pol;
        vs_d = in_vs ? act_q.vs_pol : ~act_q.vs_pol;
        x_d  = h_q;
        y_d  = v_q;
        ls_d = (h_q == '0);
        fs_d = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge pxl_clk) begin
        if (rst) begin
            h_q    <= '0;
            v_q    <= '0;
            act_q  <= DEF;
            shd_q  <= DEF;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
            de_q   <= 1'b0;
            hs_q   <= ~DEF.hs_pol;
            vs_q   <= ~DEF.vs_pol;
            x_q    <= '0;
            y_q    <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            x_q    <= x_d;
            y_q    <= y_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign cfg_pending = pend_q;
    assign cfg_err     = err_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a scaled-down default raster
// (16/2/3/4 x 10/1/2/3) so several frames and reloads fit in a short run.
module tb_video_timing_gen;

    localparam int CW = 12;

    logic          pxl_clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] cfg_h_active = '0, cfg_h_fp = '0;
    logic [CW-1:0] cfg_h_sync = '0, cfg_h_bp = '0;
    logic [CW-1:0] cfg_v_active = '0, cfg_v_fp = '0;
    logic [CW-1:0] cfg_v_sync = '0, cfg_v_bp = '0;
    logic          cfg_hs_pol = 1'b0, cfg_vs_pol = 1'b0;
    logic          cfg_load = 1'b0;
    logic          cfg_pending, cfg_err, de, hsync, vsync;
    logic [CW-1:0] x, y;
    logic          line_start, frame_start;

    video_timing_gen #(
        .CW(CW),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HS_POL(0), .VS_POL(0)
    ) dut (
        .pxl_clk(pxl_clk), .rst(rst),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp),
        .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp),
        .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .cfg_load(cfg_load), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .de(de), .hsync(hsync), .vsync(vsync), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 pxl_clk = ~pxl_clk;

    int cyc = 0;
    always @(posedge pxl_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int period; int de_cnt; int de_run; int hs_cnt; int hs_x0;
        int vs_cnt; int vs_x0; int vs_y0; int last_x; int last_y;
        bit hp; bit vp;
    } frame_t;

    typedef struct {
        int    cyc;
        int    sel;
        int    exp;
        string name;
    } pt_t;

    frame_t frame_q[$];
    pt_t    pt_q[$];

    // Hand-computed per-frame expectations for each geometry used.
    function automatic frame_t fr_d();
        return '{400, 160, 16, 48, 18, 50, 18, 11, 24, 15, 1'b0, 1'b0};
    endfunction
    function automatic frame_t fr_b();
        return '{504, 240, 20, 72, 21, 84, 21, 13, 27, 17, 1'b1, 1'b1};
    endfunction
    function automatic frame_t fr_a();
        return '{108, 48, 8, 18, 9, 12, 9, 7, 11, 8, 1'b1, 1'b0};
    endfunction
    function automatic frame_t fr_c();
        return '{224, 80, 10, 28, 12, 32, 12, 10, 15, 13, 1'b0, 1'b1};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic expect_pt(input int c, input int sel,
                             input int exp, input string name);
        pt_t p;
        int  i;
        p = '{c, sel, exp, name};
        i = 0;
        while (i < pt_q.size() && pt_q[i].cyc <= c) i++;
        pt_q.insert(i, p);
    endtask

    function automatic int sel_val(input int sel);
        case (sel)
            0:       return int'(de);
            1:       return int'(hsync);
            2:       return int'(vsync);
            3:       return int'(x);
            4:       return int'(y);
            5:       return int'(line_start);
            6:       return int'(frame_start);
            7:       return int'(cfg_pending);
            default: return int'(cfg_err);
        endcase
    endfunction

    // Monitor: point expectations by cycle, frame stats on each frame_start.
    bit     armed = 0;
    frame_t st;
    int     run;

    always @(negedge pxl_clk) begin
        pt_t    p;
        frame_t e;
        while (pt_q.size() > 0 && pt_q[0].cyc <= cyc) begin
            p = pt_q.pop_front();
            if (p.cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: check for cyc %0d missed at cyc %0d",
                         p.name, p.cyc, cyc);
            end else begin
                chk(p.name, sel_val(p.sel), p.exp);
            end
        end

        if (rst) begin
            armed = 0;
        end else begin
            if (frame_start) begin
                if (armed) begin
                    if (frame_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got frame of %0d cycles, expected none",
                                 st.period);
                    end else begin
                        e = frame_q.pop_front();
                        chk("frame_period", st.period, e.period);
                        chk("frame_de_cnt", st.de_cnt, e.de_cnt);
                        chk("frame_de_run", st.de_run, e.de_run);
                        chk("frame_hs_cnt", st.hs_cnt, e.hs_cnt);
                        chk("frame_hs_x0", st.hs_x0, e.hs_x0);
                        chk("frame_vs_cnt", st.vs_cnt, e.vs_cnt);
                        chk("frame_vs_x0", st.vs_x0, e.vs_x0);
                        chk("frame_vs_y0", st.vs_y0, e.vs_y0);
                        chk("frame_last_x", st.last_x, e.last_x);
                        chk("frame_last_y", st.last_y, e.last_y);
                    end
                end
                st = '{0, 0, 0, 0, -1, 0, -1, -1, 0, 0, 1'b0, 1'b0};
                if (frame_q.size() > 0) begin
                    st.hp = frame_q[0].hp;
                    st.vp = frame_q[0].vp;
                end
                run   = 0;
                armed = 1;
            end
            if (armed) begin
                st.period++;
                if (de) begin
                    st.de_cnt++;
                    run++;
                    if (run > st.de_run) st.de_run = run;
                end else begin
                    run = 0;
                end
                if (hsync == st.hp) begin
                    st.hs_cnt++;
                    if (y == 0 && st.hs_x0 < 0) st.hs_x0 = int'(x);
                end
                if (vsync == st.vp) begin
                    st.vs_cnt++;
                    if (st.vs_x0 < 0) begin
                        st.vs_x0 = int'(x);
                        st.vs_y0 = int'(y);
                    end
                end
                st.last_x = int'(x);
                st.last_y = int'(y);
            end
        end
    end

    task automatic wait_frame();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge pxl_clk);
            if (frame_start === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_frame: got no frame_start, expected one within 3000 cycles");
        end
    endtask

    task automatic wait_xy(input int wx, input int wy);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge pxl_clk);
            if (int'(x) == wx && int'(y) == wy) seen = 1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_xy: got no (%0d,%0d), expected within 3000 cycles",
                     wx, wy);
        end
    endtask

    task automatic load(input int ha, input int hf, input int hs, input int hb,
                        input int va, input int vf, input int vs, input int vb,
                        input bit hp, input bit vp);
        cfg_h_active = CW'(ha);
        cfg_h_fp     = CW'(hf);
        cfg_h_sync   = CW'(hs);
        cfg_h_bp     = CW'(hb);
        cfg_v_active = CW'(va);
        cfg_v_fp     = CW'(vf);
        cfg_v_sync   = CW'(vs);
        cfg_v_bp     = CW'(vb);
        cfg_hs_pol   = hp;
        cfg_vs_pol   = vp;
        cfg_load     = 1'b1;
        @(negedge pxl_clk);
        cfg_load     = 1'b0;
    endtask

    initial begin
        int k;

        // Reset state, then first output after release is pixel (0,0).
        @(negedge pxl_clk);
        k = cyc;
        expect_pt(k + 1, 0, 0, "rst_de");
        expect_pt(k + 1, 1, 1, "rst_hsync");
        expect_pt(k + 1, 2, 1, "rst_vsync");
        expect_pt(k + 1, 3, 0, "rst_x");
        expect_pt(k + 1, 6, 0, "rst_frame_start");
        expect_pt(k + 1, 7, 0, "rst_pending");
        expect_pt(k + 1, 8, 0, "rst_err");
        @(negedge pxl_clk);
        @(negedge pxl_clk);
        rst = 1'b0;
        expect_pt(k + 3, 6, 1, "first_frame_start");
        expect_pt(k + 3, 5, 1, "first_line_start");
        expect_pt(k + 3, 0, 1, "first_de");
        expect_pt(k + 3, 3, 0, "first_x");
        expect_pt(k + 3, 4, 0, "first_y");
        expect_pt(k + 4, 3, 1, "second_x");
        expect_pt(k + 4, 6, 0, "second_frame_start");
        frame_q.push_back(fr_d());
        frame_q.push_back(fr_d());
        wait_frame();
        wait_frame();
        wait_frame();

        // Reset mid-frame while both syncs are active.
        wait_xy(19, 11);
        expect_pt(cyc, 1, 0, "pre_rst_hsync_active");
        expect_pt(cyc, 2, 0, "pre_rst_vsync_active");
        k = cyc;
        rst = 1'b1;
        expect_pt(k + 1, 1, 1, "midrst_hsync");
        expect_pt(k + 1, 2, 1, "midrst_vsync");
        expect_pt(k + 2, 0, 0, "midrst_de");
        expect_pt(k + 2, 6, 0, "midrst_frame_start");
        @(negedge pxl_clk);
        @(negedge pxl_clk);
        rst = 1'b0;
        expect_pt(k + 3, 6, 1, "midrst_restart_fs");
        expect_pt(k + 3, 3, 0, "midrst_restart_x");
        expect_pt(k + 3, 4, 0, "midrst_restart_y");
        frame_q.push_back(fr_d());
        wait_frame();

        // Mid-frame reload: current frame keeps default geometry.
        wait_xy(5, 3);
        k = cyc;
        load(20, 1, 4, 3, 12, 1, 3, 2, 1'b1, 1'b1);
        expect_pt(k + 1, 7, 1, "load_b_pending");
        expect_pt(k + 1, 8, 0, "load_b_no_err");
        expect_pt(k + 100, 7, 1, "load_b_still_pending");
        frame_q.push_back(fr_b());
        wait_frame();
        expect_pt(cyc + 1, 7, 0, "b_applied_pending_clr");

        // Two loads in one frame: last writer wins.
        wait_xy(2, 2);
        k = cyc;
        load(8, 1, 2, 1, 6, 1, 1, 1, 1'b1, 1'b0);
        expect_pt(k + 1, 7, 1, "load_a_pending");
        repeat (9) @(negedge pxl_clk);
        load(10, 2, 2, 2, 8, 2, 2, 2, 1'b0, 1'b1);
        expect_pt(k + 11, 7, 1, "load_c_pending");
        frame_q.push_back(fr_c());
        wait_frame();

        // Load on the exact wrap cycle while a shadow is already pending.
        wait_xy(3, 2);
        load(8, 1, 2, 1, 6, 1, 1, 1, 1'b1, 1'b0);
        frame_q.push_back(fr_a());
        wait_xy(14, 13);
        k = cyc;
        load(20, 1, 4, 3, 12, 1, 3, 2, 1'b1, 1'b1);
        expect_pt(k + 1, 7, 1, "wrap_load_pending");
        expect_pt(k + 54, 7, 1, "wrap_mid_pending");
        expect_pt(k + 108, 7, 1, "wrap_end_pending");
        expect_pt(k + 109, 7, 0, "wrap_next_applied");
        frame_q.push_back(fr_b());
        wait_frame();
        wait_frame();

        // Rejected loads: zero active, total overflow, zero vsync.
        frame_q.push_back(fr_b());
        wait_xy(4, 4);
        k = cyc;
        load(0, 1, 1, 1, 6, 1, 1, 1, 1'b0, 1'b0);
        expect_pt(k + 1, 8, 1, "err_zero_active");
        expect_pt(k + 1, 7, 0, "err_zero_pending");
        expect_pt(k + 2, 8, 0, "err_single_pulse");
        @(negedge pxl_clk);
        load(4092, 1, 1, 2, 6, 1, 1, 1, 1'b0, 1'b0);
        expect_pt(k + 3, 8, 1, "err_overflow");
        expect_pt(k + 3, 7, 0, "err_overflow_pending");
        @(negedge pxl_clk);
        load(8, 1, 1, 1, 6, 1, 0, 1, 1'b0, 1'b0);
        expect_pt(k + 5, 8, 1, "err_zero_vsync");
        expect_pt(k + 6, 8, 0, "err_vsync_single");
        expect_pt(k + 6, 7, 0, "err_vsync_pending");
        wait_frame();
        wait_frame();
        @(negedge pxl_clk);
        @(negedge pxl_clk);

        chk("frames_left", frame_q.size(), 0);
        chk("points_left", pt_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator that supersedes the fixed 640x480 counter and sync logic in the HDMI top.
- Produces de, hsync, vsync, pixel coordinates and frame/line strobes for the TMDS encoders and OSER10 stage.
- Porch, sync and active sizes and sync polarities are compile-time defaults and can be reloaded at runtime.
- Runtime reloads use a shadow register that takes effect only at a frame boundary, so no frame is ever torn.

Parameters:
- CW, 12, width of every counter and config field.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, hsync active level (0 = active-low).
- VS_POL, 0, vsync active level (0 = active-low).

Ports:
- pxl_clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CW each  new horizontal timing.
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CW each  new vertical timing.
- cfg_hs_pol, cfg_vs_pol  in  1 each  new sync polarities.
- cfg_load  in  1  single-cycle strobe that captures all cfg_* into the shadow register.
- cfg_pending  out  1  shadow holds a config not yet applied.
- cfg_err  out  1  one-cycle pulse: the cfg_load was rejected.
- de  out  1  active-video enable.
- hsync  out  1  horizontal sync at the configured polarity.
- vsync  out  1  vertical sync at the configured polarity.
- x  out  CW  horizontal pixel coordinate of the current output cycle.
- y  out  CW  vertical line coordinate of the current output cycle.
- line_start  out  1  pulse when x==0.
- frame_start  out  1  pulse when x==0 && y==0.

Behaviour:
- Internal counters h and v, plus an active config register. Totals: HT = active+fp+sync+bp, computed per axis in CW bits.
- Counting: h increments every cycle. At h==HT-1, h wraps to 0 and v increments. At v==VT-1 on that same cycle, v wraps to 0.
- Decode from (h, v) and register. All outputs update on the same edge, describing the counter value of the previous cycle; fixed latency is 1 cycle.
  - x=h and y=v.
  - de = h<H_ACTIVE && v<V_ACTIVE.
  - Horizontal sync region: HA+HFP <= h < HA+HFP+HSYNC.
  - Vertical sync region: starts at (v==VA+VFP, h==HA+HFP) and ends at (v==VA+VFP+VSYNC, h==HA+HFP). Both vsync edges are therefore aligned to the hsync leading edge.
  - hsync = HS_POL when in the sync region, ~HS_POL otherwise. vsync uses VS_POL the same way.
- Reset (synchronous): h=v=0; active config and shadow take the parameter defaults; cfg_pending=0, cfg_err=0, de=0, x=y=0, line_start=frame_start=0; hsync=~HS_POL, vsync=~VS_POL.
  - First cycle after reset deasserts: outputs describe (0,0), with de=1, frame_start=1, line_start=1.
  - Reset mid-frame restarts the raster immediately from (0,0).
- Config validation on cfg_load:
  - Reject if any of h_active, h_sync, v_active, v_sync is 0, or if either total overflows CW bits (i.e. exceeds 2^CW-1).
  - On reject: pulse cfg_err for one cycle; shadow and cfg_pending unchanged.
  - On accept: shadow <= cfg_*, cfg_pending <= 1.
- Apply: on the wrap cycle (h==HT-1 && v==VT-1) with cfg_pending=1, active <= shadow and cfg_pending <= 0. Counters wrap to 0 as usual, and the new frame uses the new timing from pixel (0,0).
- Simultaneous cfg_load and apply on the wrap cycle:
  - The previously held shadow is applied.
  - A valid new load overwrites the shadow and cfg_pending stays 1, so it applies at the next frame end.
- cfg_load while already pending: the shadow is overwritten (last writer wins), and only the latest config applies.
- Polarity changes take effect at the apply wrap only; no glitch on hsync or vsync mid-frame.

Decomposition:
- Package video_timing_pkg:
  - typedef timing_t (packed struct of the 8 CW-wide fields plus 2 polarity bits).
  - Constant TIMING_640x480_60 with the defaults above.
  - Function timing_valid(timing_t).
- No sub-module: a single module containing the counters, the decode, and the shadow/active registers.

Test Plan:
- Defaults, run 420000 cycles:
  - frame_start exactly once per 420000 cycles.
  - de high 640 consecutive cycles per line, 307200 cycles per frame.
  - hsync low for 96 cycles starting at x=656.
  - vsync low for exactly 1600 cycles, from (656,490) to (655,492).
- Reset pulse asserted at (300,200) -> the next output is (0,0) with frame_start=1, and hsync/vsync inactive during reset.
- cfg_load mid-frame with 800x600 timing (800/40/128/88, 600/1/4/23, pol=1) ->
  - Current frame keeps the 800x525 raster and cfg_pending=1 until the wrap.
  - Next frame HT=1056, VT=628; hsync high for x 840..967; 480000 de cycles.
- cfg_load of config A, then config B 10 cycles later, same frame -> only B is applied at the wrap.
- cfg_load on the exact wrap cycle -> the prior shadow is applied, the new config is applied one frame later, and cfg_pending is 1 throughout.
- cfg_load with cfg_h_active=0 -> cfg_err single pulse; cfg_pending and raster unchanged.
